// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: IF fetch vs MEM-stage load/store, with watchdog.
// Define MEM_ARB_FAIR_EN for alternating grants under contention.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SERV_IF,
    SERV_D
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pick_d;
  logic              tmo;
  logic              done;

`ifdef MEM_ARB_FAIR_EN
  // last_d_q: 1 = data port was granted most recently
  logic last_d_q, last_d_d;
  assign pick_d = d_req & (~if_req | ~last_d_q);
`else
  assign pick_d = d_req;
`endif

  assign tmo  = ~mem_ack & (cnt_q == CNT_LAST);
  assign done = mem_ack | tmo;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    if_rdata = '0;
    d_rdata  = '0;
    err      = 1'b0;
`ifdef MEM_ARB_FAIR_EN
    last_d_d = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (d_req | if_req) begin
          cnt_d = '0;
          req_d = 1'b1;
`ifdef MEM_ARB_FAIR_EN
          last_d_d = pick_d;
`endif
          if (pick_d) begin
            state_d = SERV_D;
            we_d    = d_we;
            f3_d    = d_func3;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            state_d = SERV_IF;
            we_d    = 1'b0;
            f3_d    = 3'b010;
            addr_d  = if_addr;
            wdata_d = '0;
          end
        end
      end
      SERV_IF, SERV_D: begin
        err = tmo;
        if (state_q == SERV_D) begin
          d_ready = done;
          d_rdata = tmo ? '0 : mem_rdata;
        end else begin
          if_ready = done;
          if_rdata = tmo ? '0 : mem_rdata;
        end
        if (done) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_d_q <= 1'b0;
    else      last_d_q <= last_d_d;
  end
`endif

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_func3 = f3_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared instruction/data memory between the fetch stage (IF port) and the MEM-stage load/store path (D port). Registers the winning request onto one memory port, waits a variable number of cycles for the memory acknowledge, then returns data and a ready pulse to the owner. A watchdog aborts hung accesses. Replaces the combinational address mux in front of the shared memory so multi-cycle memories can be used.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: max busy cycles without `mem_ack` before abort; legal range 1..65535.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request, level, held until `if_ready`.
- `if_addr` in ADDR_W: fetch byte address.
- `if_rdata` out DATA_W: fetch data, valid with `if_ready`.
- `if_ready` out 1: fetch complete, one-cycle pulse.
- `d_req` in 1: data request, level, held until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_func3` in 3: access size/sign (RV32I funct3).
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data, valid with `d_ready`.
- `d_ready` out 1: data access complete, one-cycle pulse.
- `err` out 1: accompanies a ready pulse when the access timed out.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: memory write enable, registered.
- `mem_func3` out 3: registered; 3'b010 (word) for fetches.
- `mem_addr` out ADDR_W: registered address.
- `mem_wdata` out DATA_W: registered store data; 0 for fetches.
- `mem_rdata` in DATA_W: memory read data, valid with `mem_ack`.
- `mem_ack` in 1: memory completion, one cycle.
- `busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, SERV_IF, SERV_D.
- IDLE: if `d_req` → SERV_D; else if `if_req` → SERV_IF; else stay. Default priority is data over fetch, so loads/stores in flight are never blocked behind fetch.
- On grant edge: latch addr/we/func3/wdata into `mem_*`, set `mem_req`=1, clear watchdog counter.
- SERV_x: `mem_*` held constant. Owner's ready = `mem_ack` (combinational); owner's rdata = `mem_rdata` passthrough; non-owner ready = 0. On `mem_ack`: `mem_req`←0, → IDLE.
- Watchdog: counter increments each SERV cycle without `mem_ack`. When count reaches TIMEOUT-1 and `mem_ack`=0: owner gets ready=1, err=1, rdata=0; `mem_req`←0; → IDLE. An ack in that same cycle wins (normal completion, err=0).
- `mem_ack` in IDLE is ignored. Requests changing while not granted are ignored until next IDLE.
- Requester must drop or change `req` at the edge ending its ready cycle; the arbiter re-samples only in IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0. Reset mid-access discards it with no ready pulse.
- Req high in cycle 0 (IDLE) → `mem_req` high from cycle 1. Ack in cycle k≥1 → ready in cycle k.
- One IDLE cycle is inserted between consecutive accesses. Back-to-back throughput is 1 access per (latency+1) cycles.
- Simultaneous `if_req` and `d_req` in IDLE → D granted (fixed priority build).
- Timeout ready occurs in cycle TIMEOUT after the grant edge, e.g. TIMEOUT=4 gives cycle 4.

## Configuration
- `MEM_ARB_FAIR_EN` defined: a 1-bit last-grant register is added, reset to IF. When both requests are pending in IDLE, grant goes to the port not granted last; a single request is granted directly. This guarantees no starvation: each port waits at most one access.
- Undefined: fixed data-over-fetch priority, no last-grant register.

## Test plan
- Reset: drive `rst`=0 mid SERV_D with `mem_ack` pending → all outputs 0, state IDLE, no `d_ready`; after release, `if_req` gets `mem_req` 1 cycle later.
- Single fetch: `if_req`, `if_addr`=0x40, `mem_ack` 3 cycles after `mem_req` with `mem_rdata`=0x00500093 → `mem_addr`=0x40, `mem_func3`=010, `if_ready`=1 with `if_rdata`=0x00500093 exactly in the ack cycle.
- Store: `d_req`, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_func3`=000 → `mem_we`=1, `mem_wdata`=0xDEADBEEF, `mem_func3`=000; `d_ready` on ack; `if_ready` stays 0.
- Contention: both requests in the same IDLE cycle, ack latency 1, both held → without macro D serviced first then IF, one IDLE cycle between. With `MEM_ARB_FAIR_EN` and D continuously requesting, grants alternate D, IF, D, IF.
- Timeout: TIMEOUT=4, no ack → `d_ready`=1, `err`=1, `d_rdata`=0 in cycle 4 after grant, `mem_req`=0 next cycle. An ack arriving in cycle 4 instead → err=0, real data returned.
- Stray ack: `mem_ack`=1 in IDLE → no ready pulse, state unchanged.
